// File: rtl/decode_issue_buffer_if.sv
// Fetch-side and issue-side bundle of the decode/issue buffer.
// Valid/ready: a fetch group transfers when in_ready && in_valid[0]; out_accept takes head lanes 0..out_accept-1, never more than are valid.
interface decode_issue_buffer_if #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(OUT_W + 1);

  logic [IN_W-1:0]     in_valid;
  logic [32*IN_W-1:0]  in_instr;
  logic [32*IN_W-1:0]  in_pc;
  logic                in_ready;
  logic [OUT_W-1:0]    out_valid;
  logic [32*OUT_W-1:0] out_instr;
  logic [32*OUT_W-1:0] out_pc;
  logic [4*OUT_W-1:0]  out_class;
  logic [AW-1:0]       out_accept;
  logic [CW-1:0]       count;

  modport master (
    output in_valid, in_instr, in_pc, out_accept,
    input  in_ready, out_valid, out_instr, out_pc, out_class, count
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_accept,
    output in_ready, out_valid, out_instr, out_pc, out_class, count
  );
endinterface

// File: rtl/decode_issue_buffer.sv
// Decode/issue buffer: pre-decodes fetched LoongArch32 instructions into classes and issues them in order,
// serialising privileged/trapping classes. Optional DECBUF_PERF_EN adds full/serial stall counters.
module decode_issue_buffer #(
  parameter int DEPTH = 8,
  parameter int IN_W  = 2,
  parameter int OUT_W = 2
) (
  input  logic clk,
  input  logic resetn,
  input  logic flush,
  decode_issue_buffer_if.slave bus
`ifdef DECBUF_PERF_EN
  ,
  output logic [31:0] perf_full_stall,
  output logic [31:0] perf_serial_stall
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [3:0] CLS_ALU     = 4'd0;
  localparam logic [3:0] CLS_MULDIV  = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JUMP    = 4'd5;
  localparam logic [3:0] CLS_CSR     = 4'd6;
  localparam logic [3:0] CLS_TLB     = 4'd7;
  localparam logic [3:0] CLS_ERTN    = 4'd8;
  localparam logic [3:0] CLS_SYSCALL = 4'd9;
  localparam logic [3:0] CLS_BREAK   = 4'd10;
  localparam logic [3:0] CLS_RDCNT   = 4'd11;
  localparam logic [3:0] CLS_INE     = 4'd15;

  // Opcode field values mirror the cpuDefine constants (LA32R encoding).
  localparam logic [16:0] OP_BREAK   = 17'h00054;
  localparam logic [16:0] OP_SYSCALL = 17'h00056;
  localparam logic [16:0] OP_IDLE    = 17'h00C91;
  localparam logic [16:0] OP_INVTLB  = 17'h00C93;
  localparam logic [7:0]  OP_CSR     = 8'h04;
  localparam logic [7:0]  OP_LL_W    = 8'h20;
  localparam logic [7:0]  OP_SC_W    = 8'h21;
  localparam logic [31:0] INS_TLBSRCH = 32'h0648_2800;
  localparam logic [31:0] INS_TLBRD   = 32'h0648_2C00;
  localparam logic [31:0] INS_TLBWR   = 32'h0648_3000;
  localparam logic [31:0] INS_TLBFILL = 32'h0648_3400;
  localparam logic [31:0] INS_ERTN    = 32'h0648_3800;

  function automatic logic [3:0] decode_class(input logic [31:0] ins);
    logic [3:0] c;
    c = CLS_INE;
    if (ins[31:26] inside {6'h16, 6'h17, 6'h18, 6'h19, 6'h1a, 6'h1b})
      c = CLS_BRANCH;
    else if (ins[31:26] inside {6'h13, 6'h14, 6'h15})
      c = CLS_JUMP;
    else if (ins[31:24] == OP_CSR)
      c = CLS_CSR;
    else if (ins[31:24] == OP_LL_W)
      c = CLS_LOAD;
    else if (ins[31:24] == OP_SC_W)
      c = CLS_STORE;
    else if (ins[31:22] inside {10'h0a0, 10'h0a1, 10'h0a2, 10'h0a8, 10'h0a9})
      c = CLS_LOAD;
    else if (ins[31:22] inside {10'h0a4, 10'h0a5, 10'h0a6})
      c = CLS_STORE;
    else if (ins[31:22] inside {10'h008, 10'h009, 10'h00a, 10'h00d, 10'h00e, 10'h00f})
      c = CLS_ALU;
    else if (ins[31:25] inside {7'h0a, 7'h0e})
      c = CLS_ALU;
    else if (ins[31:15] inside {17'h20, 17'h22, 17'h24, 17'h25, 17'h28, 17'h29, 17'h2a,
                                17'h2b, 17'h2e, 17'h2f, 17'h30, 17'h81, 17'h89, 17'h91})
      c = CLS_ALU;
    else if (ins[31:15] inside {17'h38, 17'h39, 17'h3a, 17'h40, 17'h41, 17'h42, 17'h43})
      c = CLS_MULDIV;
    else if (ins[31:15] == OP_BREAK)
      c = CLS_BREAK;
    else if (ins[31:15] == OP_SYSCALL)
      c = CLS_SYSCALL;
    else if (ins == INS_TLBSRCH || ins == INS_TLBRD || ins == INS_TLBWR ||
             ins == INS_TLBFILL || ins[31:15] == OP_INVTLB)
      c = CLS_TLB;
    else if (ins == INS_ERTN || ins[31:15] == OP_IDLE)
      c = CLS_ERTN;
    else if (ins[31:10] inside {22'h18, 22'h19})
      c = CLS_RDCNT;
    return c;
  endfunction

  function automatic logic is_serial(input logic [3:0] c);
    return (c inside {[CLS_CSR:CLS_RDCNT]}) || (c == CLS_INE);
  endfunction

  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];
  logic [3:0]  cls_mem   [DEPTH];

  logic [PW-1:0]    head, tail;
  logic [CW-1:0]    count;
  logic [CW-1:0]    push_n, pop_n, vld_n;
  logic             do_push, ready;
  logic [OUT_W-1:0] vld, ser;
  logic             open;

  assign ready   = (CW'(DEPTH) - count) >= CW'(IN_W);
  assign do_push = !flush && ready && bus.in_valid[0];
  assign pop_n   = CW'(bus.out_accept);

  always_comb begin
    push_n = '0;
    for (int i = 0; i < IN_W; i++)
      if (bus.in_valid[i]) push_n = push_n + CW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop_n);
      if (do_push) tail <= tail + PW'(push_n);
      count <= count + (do_push ? push_n : '0) - pop_n;
    end
  end

  // Storage contents are don't-care after reset; lane valids gate every read.
  always_ff @(posedge clk) begin
    if (do_push) begin
      for (int i = 0; i < IN_W; i++) begin
        if (bus.in_valid[i]) begin
          pc_mem[tail + PW'(i)]    <= bus.in_pc[32*i +: 32];
          instr_mem[tail + PW'(i)] <= bus.in_instr[32*i +: 32];
          cls_mem[tail + PW'(i)]   <= decode_class(bus.in_instr[32*i +: 32]);
        end
      end
    end
  end

  // A serialising entry closes every lane after it, and a serialising head closes all lanes but 0.
  always_comb begin
    open  = 1'b1;
    vld   = '0;
    ser   = '0;
    vld_n = '0;
    for (int i = 0; i < OUT_W; i++) begin
      ser[i] = is_serial(cls_mem[head + PW'(i)]);
      if (i != 0 && (ser[i] || ser[0])) open = 1'b0;
      vld[i] = open && (CW'(i) < count);
      if (vld[i]) vld_n = vld_n + CW'(1);
    end
  end

  always_comb begin
    bus.out_instr = '0;
    bus.out_pc    = '0;
    bus.out_class = '0;
    for (int i = 0; i < OUT_W; i++) begin
      if (vld[i]) begin
        bus.out_instr[32*i +: 32] = instr_mem[head + PW'(i)];
        bus.out_pc[32*i +: 32]    = pc_mem[head + PW'(i)];
        bus.out_class[4*i +: 4]   = cls_mem[head + PW'(i)];
      end
    end
  end

  assign bus.out_valid = vld;
  assign bus.in_ready  = ready;
  assign bus.count     = count;

`ifdef DECBUF_PERF_EN
  logic [CW-1:0] lane_cap;
  assign lane_cap = (count < CW'(OUT_W)) ? count : CW'(OUT_W);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_full_stall   <= '0;
      perf_serial_stall <= '0;
    end else begin
      if (bus.in_valid[0] && !ready && perf_full_stall != '1)
        perf_full_stall <= perf_full_stall + 32'd1;
      if (vld_n < lane_cap && perf_serial_stall != '1)
        perf_serial_stall <= perf_serial_stall + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_decode_issue_buffer.sv
// Directed bench for decode_issue_buffer: vector table for fill/drain/serialise/flush plus
// hand-written wrap-around, asynchronous reset and (with DECBUF_PERF_EN) stall counter sequences.
module tb_decode_issue_buffer;
  localparam int DEPTH = 8;
  localparam int IN_W  = 2;
  localparam int OUT_W = 2;

  localparam logic [31:0] P       = 32'h1c00_0000;
  localparam logic [31:0] ADD_W   = 32'h0010_1885;
  localparam logic [31:0] LD_W    = 32'h2880_0085;
  localparam logic [31:0] ST_W    = 32'h2980_0085;
  localparam logic [31:0] MUL_W   = 32'h001c_0c41;
  localparam logic [31:0] BEQ     = 32'h5800_0485;
  localparam logic [31:0] BL      = 32'h5400_0100;
  localparam logic [31:0] ADDI_W  = 32'h0280_0484;
  localparam logic [31:0] CSRWR   = 32'h0400_0024;
  localparam logic [31:0] SYSCALL = 32'h002b_0000;
  localparam logic [31:0] INE     = 32'hffff_ffff;

  logic clk, resetn, flush;
  int   pass_cnt, total_cnt;
  logic [31:0] exp_q[$];

  decode_issue_buffer_if #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)) bus ();

`ifdef DECBUF_PERF_EN
  logic [31:0] perf_full_stall, perf_serial_stall;
`endif

  decode_issue_buffer #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk(clk),
    .resetn(resetn),
    .flush(flush),
    .bus(bus)
`ifdef DECBUF_PERF_EN
    ,
    .perf_full_stall(perf_full_stall),
    .perf_serial_stall(perf_serial_stall)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (resetn)
      assert (int'(bus.out_accept) <= $countones(bus.out_valid))
        else $error("out_accept exceeds valid lanes");

  typedef struct {
    logic [1:0]  iv;
    logic [31:0] i0, p0, i1, p1;
    logic [1:0]  acc;
    logic        fl;
    logic [1:0]  ev;
    logic [3:0]  ec;
    logic        er;
    logic [3:0]  c0, c1;
    logic [31:0] ep;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic drive(input logic [1:0] iv, input logic [31:0] i0, input logic [31:0] p0,
                       input logic [31:0] i1, input logic [31:0] p1,
                       input logic [1:0] acc, input logic fl);
    bus.in_valid   = iv;
    bus.in_instr   = {i1, i0};
    bus.in_pc      = {p1, p0};
    bus.out_accept = acc;
    flush          = fl;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
  endtask

  task automatic check_row(input int r, input vec_t v);
    check($sformatf("row%0d_valid", r), 32'(bus.out_valid), 32'(v.ev));
    check($sformatf("row%0d_count", r), 32'(bus.count), 32'(v.ec));
    check($sformatf("row%0d_ready", r), 32'(bus.in_ready), 32'(v.er));
    check($sformatf("row%0d_cls0", r), 32'(bus.out_class[3:0]), 32'(v.c0));
    check($sformatf("row%0d_cls1", r), 32'(bus.out_class[7:4]), 32'(v.c1));
    check($sformatf("row%0d_pc0", r), bus.out_pc[31:0], v.ep);
  endtask

  initial begin
    logic [31:0] pc;
    pass_cnt  = 0;
    total_cnt = 0;
    //                iv     i0       p0       i1      p1       acc  fl  ev     ec  er  c0  c1  ep
    vecs[0]  = '{2'b11, ADD_W,  P,       LD_W,  P+4,     2'd0, 0, 2'b11, 2,  1,  0,  2,  P};
    vecs[1]  = '{2'b11, MUL_W,  P+8,     ST_W,  P+'hc,   2'd0, 0, 2'b11, 4,  1,  0,  2,  P};
    vecs[2]  = '{2'b11, BEQ,    P+'h10,  BL,    P+'h14,  2'd0, 0, 2'b11, 6,  1,  0,  2,  P};
    vecs[3]  = '{2'b11, ADD_W,  P+'h18,  ADD_W, P+'h1c,  2'd0, 0, 2'b11, 8,  0,  0,  2,  P};
    vecs[4]  = '{2'b11, ADD_W,  P+'h80,  ADD_W, P+'h84,  2'd2, 0, 2'b11, 6,  1,  1,  3,  P+8};
    vecs[5]  = '{2'b00, 0,      0,       0,     0,       2'd2, 0, 2'b11, 4,  1,  4,  5,  P+'h10};
    vecs[6]  = '{2'b00, 0,      0,       0,     0,       2'd2, 0, 2'b11, 2,  1,  0,  0,  P+'h18};
    vecs[7]  = '{2'b00, 0,      0,       0,     0,       2'd2, 0, 2'b00, 0,  1,  0,  0,  0};
    vecs[8]  = '{2'b11, ADDI_W, P+'h20,  CSRWR, P+'h24,  2'd0, 0, 2'b01, 2,  1,  0,  0,  P+'h20};
    vecs[9]  = '{2'b01, ADD_W,  P+'h28,  0,     0,       2'd1, 0, 2'b01, 2,  1,  6,  0,  P+'h24};
    vecs[10] = '{2'b00, 0,      0,       0,     0,       2'd1, 0, 2'b01, 1,  1,  0,  0,  P+'h28};
    vecs[11] = '{2'b11, INE,    P+'h2c,  ADD_W, P+'h30,  2'd1, 0, 2'b01, 2,  1,  15, 0,  P+'h2c};
    vecs[12] = '{2'b00, 0,      0,       0,     0,       2'd1, 0, 2'b01, 1,  1,  0,  0,  P+'h30};
    vecs[13] = '{2'b11, SYSCALL,P+'h34,  ADD_W, P+'h38,  2'd1, 0, 2'b01, 2,  1,  9,  0,  P+'h34};
    vecs[14] = '{2'b00, 0,      0,       0,     0,       2'd1, 0, 2'b01, 1,  1,  0,  0,  P+'h38};
    vecs[15] = '{2'b11, LD_W,   P+'h3c,  LD_W,  P+'h40,  2'd0, 0, 2'b11, 3,  1,  0,  2,  P+'h38};
    vecs[16] = '{2'b11, ST_W,   P+'h44,  ST_W,  P+'h48,  2'd0, 0, 2'b11, 5,  1,  0,  2,  P+'h38};
    vecs[17] = '{2'b11, ADD_W,  P+'h4c,  ADD_W, P+'h50,  2'd2, 1, 2'b00, 0,  1,  0,  0,  0};

    resetn = 1'b0;
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_valid", 32'(bus.out_valid), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_instr", bus.out_instr[31:0], 32'd0);
    check("rst_pc", bus.out_pc[31:0], 32'd0);
    check("rst_class", 32'(bus.out_class), 32'd0);

    // driver: vector table
    for (int r = 0; r < 18; r++) begin
      drive(vecs[r].iv, vecs[r].i0, vecs[r].p0, vecs[r].i1, vecs[r].p1, vecs[r].acc, vecs[r].fl);
      step();
      check_row(r, vecs[r]);
    end

    // wrap-around: scoreboard of PCs, two in and two out every cycle
    pc = 32'h1c00_1000;
    drive(2'b11, ADD_W, pc, ADD_W, pc + 4, 2'd0, 1'b0);
    exp_q.push_back(pc);
    exp_q.push_back(pc + 4);
    pc = pc + 8;
    step();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("wrap%0d_pc0", c), bus.out_pc[31:0], exp_q[0]);
      check($sformatf("wrap%0d_pc1", c), bus.out_pc[63:32], exp_q[1]);
      drive(2'b11, ADD_W, pc, ADD_W, pc + 4, 2'd2, 1'b0);
      void'(exp_q.pop_front());
      void'(exp_q.pop_front());
      exp_q.push_back(pc);
      exp_q.push_back(pc + 4);
      pc = pc + 8;
      step();
      check($sformatf("wrap%0d_count", c), 32'(bus.count), 32'd2);
    end
    check("wrap_last_pc0", bus.out_pc[31:0], exp_q[0]);
    drive(2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'd2, 1'b0);
    step();
    check("wrap_drain_count", 32'(bus.count), 32'd0);

    // asynchronous reset in the middle of a cycle
    drive(2'b11, ADD_W, P, ADD_W, P + 4, 2'd0, 1'b0);
    step();
    check("pre_arst_count", 32'(bus.count), 32'd2);
    #2 resetn = 1'b0;
    #1;
    check("arst_count", 32'(bus.count), 32'd0);
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    resetn = 1'b1;

`ifdef DECBUF_PERF_EN
    for (int k = 0; k < 4; k++) begin
      drive(2'b11, ADD_W, P + 8 * k, ADD_W, P + 8 * k + 4, 2'd0, 1'b0);
      step();
    end
    check("perf_fill_count", 32'(bus.count), 32'd8);
    for (int k = 0; k < 3; k++) begin
      drive(2'b01, ADD_W, P + 'h40, 32'h0, 32'h0, 2'd0, 1'b0);
      step();
    end
    step();
    check("perf_full_stall", perf_full_stall, 32'd3);
    check("perf_serial_stall", perf_serial_stall, 32'd0);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/decode_issue_buffer.md
# decode_issue_buffer

Parametrised decode/issue buffer between instruction fetch and the execute pipeline. Accepts up to `IN_W` fetched instructions per cycle, pre-decodes each into a 4-bit instruction class on entry, and holds them in a circular queue. Presents up to `OUT_W` in-order entries per cycle to issue logic. Single-issue serialisation of privileged and trapping instructions is enforced here, so downstream issue logic needs no knowledge of those rules.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥ `IN_W` and ≥ `OUT_W`.
- `IN_W`, 2: fetch lanes per cycle, 1..4.
- `OUT_W`, 2: issue lanes per cycle, 1..4.

- `clk`  in  1  clock.
- `resetn`  in  1  asynchronous active-low reset.
- `flush`  in  1  discard all entries; inputs in the same cycle are ignored.
- `in_valid`  in  `IN_W`  per-lane valid; lanes contiguous from lane 0.
- `in_instr`  in  `32*IN_W`  instruction words, lane i at [32i+31:32i].
- `in_pc`  in  `32*IN_W`  PCs, same packing.
- `in_ready`  out  1  queue can take a full `IN_W` group this cycle.
- `out_valid`  out  `OUT_W`  per-lane valid, contiguous from lane 0.
- `out_instr`  out  `32*OUT_W`  head-ordered instruction words.
- `out_pc`  out  `32*OUT_W`  head-ordered PCs.
- `out_class`  out  `4*OUT_W`  decoded class per lane.
- `out_accept`  in  `$clog2(OUT_W+1)`  number of lanes consumed this cycle, 0..popcount(`out_valid`).
- `count`  out  `$clog2(DEPTH+1)`  occupied entries.

## Operation
- Class encodings, using opcode constants from `cpuDefine`:
  - 0 ALU/shift/imm/LUI/PCADDU12I
  - 1 MUL/DIV/MOD
  - 2 load incl. LL
  - 3 store incl. SC
  - 4 conditional branch
  - 5 B/BL/JIRL
  - 6 CSR
  - 7 TLB incl. INVTLB
  - 8 ERTN/IDLE
  - 9 SYSCALL
  - 10 BREAK
  - 11 RDCNT*
  - 15 INE (no other match)
  - 12–14 reserved, never produced.
- Storage: `DEPTH` entries of {pc, instr, class}; head/tail pointers `$clog2(DEPTH)` bits wide, wrapping modulo `DEPTH`; `count` register.
- Push: when `in_ready` and `in_valid[0]` are both high, write popcount(`in_valid`) lanes at tail in lane order and advance tail by that number. Class is computed combinationally on write.
- Pop: advance head by `out_accept`. If `out_accept` exceeds the valid lanes, that is a protocol violation; the bench asserts on it.
- Serialising classes (6–11, 15):
  - Only ever presented on lane 0.
  - When presented, all other lanes are invalid.
  - A serialising entry at head position k>0 truncates `out_valid` to lanes 0..k-1.
- `out_valid[i]` = (i < count) and not truncated by the serialising rule.
- Simultaneous push and pop in one cycle: count_next = count + pushed − `out_accept`.
- `flush` has priority over push and pop: head = tail = count = 0.

## Timing
- Reset values:
  - `count`, head, tail, `out_valid`: 0.
  - `out_instr`, `out_pc`, `out_class`: 0.
  - `in_ready`: 1.
- `in_ready` = (`DEPTH` − count) ≥ `IN_W`, computed from the registered count only. A pop in the same cycle does not raise it; this is a deliberate timing cut.
- Latency: an instruction pushed at edge N is visible on `out_*` after edge N (1 cycle). There is no same-cycle bypass.
- Outputs are combinational reads of registered storage at head.
- Flush: asserted in cycle N gives all `out_valid` = 0 and count = 0 after edge N.
- Reset asserted mid-operation clears the queue immediately (asynchronous). Storage data is don't-care after reset; only valids matter.

## Configuration
- `DECBUF_PERF_EN` defined: adds two 32-bit saturating counters.
  - `perf_full_stall`: cycles with `in_valid[0]` && !`in_ready`.
  - `perf_serial_stall`: cycles where serialisation truncated `out_valid` below min(count, `OUT_W`).
  - Both are exposed as output ports, reset to 0, and cleared by reset only (not by flush).
- `DECBUF_PERF_EN` undefined: these ports and counters do not exist.

## Test plan
- Reset and basic fill:
  - Stimulus: after reset, push {ADD.W @0x1c000000, LD.W @0x1c000004}, `out_accept`=0.
  - Response: next cycle `out_valid`=2'b11, classes {0,2}, `count`=2.
- Full condition (DEPTH=8, IN_W=2):
  - Stimulus: push 4 pairs with no pops.
  - Response: `count`=8, `in_ready`=0. Then accepting 2 while pushing gives count 6 next cycle, and `in_ready` stays 0 during the accept cycle.
- Serialisation:
  - Stimulus: queue {ADDI.W, CSRWR, ADD.W}.
  - Response: `out_valid`=2'b01 with class 0. After accepting 1, `out_valid`=2'b01 with class 6 (CSRWR alone). After accepting 1, ADD.W is shown on lane 0.
- Wrap-around:
  - Stimulus: push and pop 2 per cycle for 10 cycles with sequential PCs.
  - Response: `out_pc` strictly sequential across the pointer wrap; `count` constant at 2.
- Flush priority:
  - Stimulus: `count`=5; assert `flush` together with a push and `out_accept`=2.
  - Response: next cycle `count`=0, `out_valid`=0, `in_ready`=1.
- INE and perf:
  - Stimulus: push 0xFFFFFFFF.
  - Response: class 15, issued alone.
  - With `DECBUF_PERF_EN`: hold the queue full with `in_valid`=1 for 3 cycles; `perf_full_stall` reads 3.
